// File: rtl/debug_cmd_rx.sv
// debug_cmd_rx: host-to-board command parser for the USB debug link.
// Takes the byte stream from usb_serial, assembles fixed 5-byte frames
// (SYNC, OP, ADDR, DATA, CHK) and drives the CPU debug controls: a halt
// level, a single-step pulse and a register-write valid/ready handshake.
// Framing problems (bad checksum, unknown opcode, inter-byte timeout and
// bytes arriving while a write is still pending) bump a saturating counter.
module debug_cmd_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         ADDR_W         = 4,
    parameter int         TIMEOUT_CYCLES = 12000,
    parameter int         TIMEOUT_W      = 14,
    parameter logic       HALT_ON_RESET  = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_strobe,
    input  logic [7:0]        rx_data,
    output logic              halted,
    output logic              step_pulse,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam logic [7:0] OP_HALT  = 8'h01;
    localparam logic [7:0] OP_RUN   = 8'h02;
    localparam logic [7:0] OP_STEP  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h04;

    // Last idle count before the limit; an idle cycle seen here is the one
    // that reaches TIMEOUT_CYCLES and therefore fires the timeout.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GOT_SYNC,
        GOT_OP,
        GOT_ADDR,
        GOT_DATA,
        EXEC
    } state_t;

    state_t                state, state_d;
    logic [7:0]            op_q, addr_q, data_q;
    logic [7:0]            op_d, addr_d, data_d;
    logic [TIMEOUT_W-1:0]  tmo_cnt, tmo_d;
    logic                  halted_d, step_d, wr_valid_d;
    logic [ADDR_W-1:0]     wr_addr_d;
    logic [7:0]            wr_data_d;
    logic                  err_inc;
    logic                  in_frame;

    // State register; reset abandons any partial frame or pending write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic plus the next value of every registered output.
    always_comb begin
        state_d    = state;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tmo_d      = '0;
        halted_d   = halted;
        step_d     = 1'b0;
        wr_valid_d = wr_valid;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        err_inc    = 1'b0;
        in_frame   = (state == GOT_SYNC) || (state == GOT_OP) ||
                     (state == GOT_ADDR) || (state == GOT_DATA);

        case (state)
            IDLE: begin
                if (rx_strobe && (rx_data == SYNC_BYTE)) begin
                    state_d = GOT_SYNC;
                end
            end
            GOT_SYNC: begin
                if (rx_strobe) begin
                    op_d    = rx_data;
                    state_d = GOT_OP;
                end
            end
            GOT_OP: begin
                if (rx_strobe) begin
                    addr_d  = rx_data;
                    state_d = GOT_ADDR;
                end
            end
            GOT_ADDR: begin
                if (rx_strobe) begin
                    data_d  = rx_data;
                    state_d = GOT_DATA;
                end
            end
            GOT_DATA: begin
                if (rx_strobe) begin
                    state_d = IDLE;
                    if (rx_data != (op_q ^ addr_q ^ data_q)) begin
                        err_inc = 1'b1;
                    end else begin
                        case (op_q)
                            OP_HALT:  halted_d = 1'b1;
                            OP_RUN:   halted_d = 1'b0;
                            OP_STEP:  step_d   = halted;
                            OP_WRITE: begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = addr_q[ADDR_W-1:0];
                                wr_data_d  = data_q;
                                state_d    = EXEC;
                            end
                            default:  err_inc = 1'b1;
                        endcase
                    end
                end
            end
            EXEC: begin
                if (rx_strobe) begin
                    err_inc = 1'b1;
                end
                if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_frame && !rx_strobe) begin
            if (tmo_cnt == TMO_LAST) begin
                err_inc = 1'b1;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_cnt + 1'b1;
            end
        end
    end

    // Frame fields, timeout counter, registered outputs and error counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            tmo_cnt    <= '0;
            halted     <= HALT_ON_RESET;
            step_pulse <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            err_count  <= '0;
            busy       <= 1'b0;
        end else begin
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tmo_cnt    <= tmo_d;
            halted     <= halted_d;
            step_pulse <= step_d;
            wr_valid   <= wr_valid_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            busy       <= (state_d != IDLE);
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/debug_cmd_rx.md
Name: debug_cmd_rx

Overview:
- Host-to-board half of the USB debug link; the board-to-host half streams 8 debug bytes plus an 0xFF marker.
- Consumes the byte stream delivered by usb_serial (uart_rx_strobe / uart_rx_data) in the clk_logic (12 MHz) domain.
- Parses fixed 5-byte command frames and drives CPU debug controls: halt level, single-step pulse, and a register-write handshake.
- Maintains a saturating error counter, which the team places in a spare debug byte slot.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every command frame.
- ADDR_W, 4, width of wr_addr; the low ADDR_W bits of the ADDR byte are used.
- TIMEOUT_CYCLES, 12000, maximum clk cycles between bytes inside a frame (1 ms at 12 MHz).
- TIMEOUT_W, 14, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES.
- HALT_ON_RESET, 0, reset value of the halted output.

Ports:
- clk  input  1  logic clock (clk_logic domain)
- resetn  input  1  asynchronous active-low reset
- rx_strobe  input  1  one-cycle pulse; rx_data is valid this cycle
- rx_data  input  8  received byte
- halted  output  1  CPU halt request level
- step_pulse  output  1  one-cycle single-step request
- wr_valid  output  1  register write pending
- wr_ready  input  1  consumer accepts write
- wr_addr  output  ADDR_W  write register index
- wr_data  output  8  write value
- err_count  output  8  saturating frame-error count
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, resetn low):
  - FSM enters IDLE.
  - halted = HALT_ON_RESET; step_pulse = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; err_count = 0; timeout counter = 0.
  - A reset asserted mid-frame or mid-handshake abandons the frame with no error counted.
- Frame format: SYNC, OP, ADDR, DATA, CHK, where CHK = OP ^ ADDR ^ DATA. The frame length is always 5 bytes.
- Opcodes:
  - 8'h01 HALT: halted <= 1.
  - 8'h02 RUN: halted <= 0.
  - 8'h03 STEP: step_pulse for one cycle, only if halted = 1; otherwise no effect and no error.
  - 8'h04 WRITE: wr handshake using ADDR and DATA.
  - Any other value is an error.
- FSM states: IDLE, GOT_SYNC, GOT_OP, GOT_ADDR, GOT_DATA, EXEC.
- Transitions:
  - IDLE: rx_strobe with rx_data == SYNC_BYTE -> GOT_SYNC. Any other byte is discarded silently (resync, no error).
  - GOT_SYNC: next strobe latches OP -> GOT_OP. GOT_OP latches ADDR -> GOT_ADDR. GOT_ADDR latches DATA -> GOT_DATA. A byte equal to SYNC_BYTE inside a frame is ordinary data.
  - GOT_DATA, strobe = CHK byte:
    - Checksum mismatch or unknown OP: err_count++, go to IDLE.
    - HALT/RUN: halted updates on the next edge; go to IDLE.
    - STEP: step_pulse is high exactly the cycle after the CHK strobe; go to IDLE.
    - WRITE: wr_valid, wr_addr, wr_data are valid from the cycle after the CHK strobe; go to EXEC.
  - EXEC:
    - wr_valid is held high and wr_addr/wr_data are held stable until a cycle with wr_valid && wr_ready.
    - wr_valid drops on the following edge and the FSM returns to IDLE.
    - wr_ready high in the first wr_valid cycle gives a 1-cycle handshake.
- Overrun: any rx_strobe while in EXEC, including the completing handshake cycle, drops the byte and increments err_count.
- Timeout:
  - The counter runs only in GOT_SYNC..GOT_DATA and clears on every rx_strobe.
  - When it reaches TIMEOUT_CYCLES with no strobe: err_count++, go to IDLE, partial frame discarded.
  - A strobe arriving in the same cycle the limit is reached is accepted; the timeout does not fire.
- err_count saturates at 8'hFF and never wraps. Only reset clears it.
- All outputs are registered. There is no combinational path from rx_* or wr_ready to any output.
- step_pulse is in the clk domain. Stretching or synchronising it into the slow CPU clock is the consumer's responsibility.

Test Plan:
- Reset, then frame A5 01 00 00 01 -> halted = 1 the cycle after the 5th strobe; err_count = 0; busy = 0.
- halted = 1, frame A5 03 00 00 03 -> step_pulse high exactly 1 cycle. Repeat with halted = 0 -> no pulse, err_count unchanged.
- Frame A5 04 03 5A 5D with wr_ready held low 4 cycles, then high -> wr_valid high 5 cycles with wr_addr = 3, wr_data = 8'h5A; drops the next cycle; second strobe during EXEC -> err_count +1.
- Bad checksum A5 02 00 00 00 -> halted unchanged, err_count = 1. Unknown op A5 07 00 00 07 -> err_count = 2. Leading garbage 11 22 before a valid frame -> accepted with no error.
- A5 01, then idle TIMEOUT_CYCLES -> err_count +1 and IDLE. A strobe at exactly TIMEOUT_CYCLES-1 idle cycles -> no timeout; frame completes.
- Force 260 errors -> err_count stays 8'hFF. Assert resetn low mid-frame -> all outputs at reset values immediately (asynchronous reset).
